serial_add_unit: RTL



---
 rtl/serial_add_unit_if.sv | 34 +++
 rtl/serial_add_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/serial_add_unit_if.sv
// ============================================================================
// Module      : serial_add_unit_if
// Description : Operand/result handshake bundle for serial_add_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_add_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Source/consumer side: drives operands and accepts results.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

`default_nettype wire

// File: rtl/serial_add_unit.sv
// ============================================================================
// Module      : serial_add_unit
// Description : Bit-serial adder, one full-add slice plus carry flop, LSB
//               first. Optional subtract path under macro SERIAL_ADD_SUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_unit #(
    parameter int WIDTH = 8
) (
    input  wire                logic clk,
    input  wire                logic rst,
    serial_add_unit_if.slave   bus
);

    localparam int             c_CW   = $clog2(WIDTH) + 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_in_ready;
    logic               w_out_valid;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_carry;
    logic [c_CW-1:0]    r_count;

    logic               w_s;
    logic               w_maj;
    logic [WIDTH-1:0]   w_sum_next;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_load;

`ifdef SERIAL_ADD_SUB_EN
    // Subtract as a + ~b + 1; cin is overridden by the forced carry.
    assign w_b_load = bus.sub ? ~bus.b : bus.b;
    assign w_c_load = bus.sub ? 1'b1   : bus.cin;
`else
    logic w_unused_sub;
    assign w_unused_sub = bus.sub;
    assign w_b_load     = bus.b;
    assign w_c_load     = bus.cin;
`endif

    // Single full-add slice on the current LSBs.
    assign w_s   = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_maj = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);

    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_next = w_s;
        end else begin : g_sum_wn
            assign w_sum_next = {w_s, r_sum[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_count == c_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= w_b_load;
                        r_carry <= w_c_load;
                        r_count <= '0;
                        r_sum   <= '0;
                    end
                end
                S_RUN: begin
                    r_carry <= w_maj;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_sum   <= w_sum_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == c_LAST) begin
                        r_cout <= w_maj;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;

endmodule

`default_nettype wire
